// File: rtl/glb_ctrl.sv
// -----------------------------------------------------------------------------
// glb_ctrl
//
// Sequencer for the global buffer (GLB): PE_SIZE column FIFOs whose read
// enables are skewed inside the GLB itself. For every tile the controller
// runs three phases:
//   FILL  - accept PE_SIZE rows from the upstream source, one GLB write each
//   DRAIN - assert the column-0 read enable for PE_SIZE consecutive cycles
//   SKEW  - wait PE_SIZE cycles for the skewed column reads to finish
// and repeats for the programmed number of tiles. Row data goes straight
// from the source to the GLB write port; only the enables come from here.
//
// Ports
//   clk          clock, all logic on the rising edge
//   rst          asynchronous reset, active high
//   start_i      one-cycle start pulse, only honoured while idle
//   num_tiles_i  number of tiles to process, latched on an accepted start
//   src_valid_i  upstream row valid
//   src_ready_o  controller accepts a row this cycle (FILL only)
//   glb_wren_o   GLB write enable (src_valid_i & src_ready_o)
//   glb_rden_o   GLB column-0 read enable (DRAIN only)
//   glb_full_i   per-column GLB full flags
//   glb_empty_i  per-column GLB empty flags
//   busy_o       high in every state except IDLE
//   tile_done_o  one-cycle pulse when a tile has been fully drained
//   done_o       one-cycle pulse when all tiles are finished
//   err_o        sticky error (underflow or residue after skew flush);
//                cleared by rst or an accepted start
// -----------------------------------------------------------------------------
module glb_ctrl #(
    parameter int PE_SIZE = 16,
    parameter int TILE_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [TILE_W-1:0]   num_tiles_i,
    input  logic                src_valid_i,
    output logic                src_ready_o,
    output logic                glb_wren_o,
    output logic                glb_rden_o,
    input  logic [PE_SIZE-1:0]  glb_full_i,
    input  logic [PE_SIZE-1:0]  glb_empty_i,
    output logic                busy_o,
    output logic                tile_done_o,
    output logic                done_o,
    output logic                err_o
);

    // One counter serves FILL (rows), DRAIN (read strobes) and SKEW (flush
    // cycles); every phase is exactly PE_SIZE long, so it always ends on the
    // same terminal value and is rewound to 0 on each phase change.
    localparam int CW = (PE_SIZE > 1) ? $clog2(PE_SIZE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PE_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DRAIN,
        SKEW,
        FIN
    } state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [TILE_W-1:0]  tile_cnt_reg, tile_cnt_next;
    logic [TILE_W-1:0]  num_reg, num_next;
    logic               err_reg, err_next;

    logic               cnt_last;
    logic [TILE_W-1:0]  tile_inc;
    logic               row_ready;
    logic               row_write;
    logic               any_full;
    logic               all_empty;

    assign cnt_last  = (cnt_reg == CNT_LAST);
    assign tile_inc  = tile_cnt_reg + 1'b1;
    assign any_full  = |glb_full_i;
    assign all_empty = &glb_empty_i;

    // A row can only be taken while filling and no column FIFO is full.
    assign row_ready = (state_reg == FILL) && !any_full;
    assign row_write = row_ready && src_valid_i;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            tile_cnt_reg <= '0;
            num_reg      <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            tile_cnt_reg <= tile_cnt_next;
            num_reg      <= num_next;
            err_reg      <= err_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // Outputs are decoded from the current state so that an asynchronous
    // reset forces them low in the same cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        tile_cnt_next = tile_cnt_reg;
        num_next      = num_reg;
        err_next      = err_reg;

        src_ready_o   = 1'b0;
        glb_wren_o    = 1'b0;
        glb_rden_o    = 1'b0;
        tile_done_o   = 1'b0;
        done_o        = 1'b0;
        busy_o        = (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    num_next      = num_tiles_i;
                    err_next      = 1'b0;
                    tile_cnt_next = '0;
                    cnt_next      = '0;
                    // A zero-tile request completes immediately.
                    state_next    = (num_tiles_i == '0) ? FIN : FILL;
                end
            end

            FILL: begin
                src_ready_o = row_ready;
                glb_wren_o  = row_write;
                // Source stalls simply hold the state and counter.
                if (row_write) begin
                    if (cnt_last) begin
                        cnt_next   = '0;
                        state_next = DRAIN;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            DRAIN: begin
                glb_rden_o = 1'b1;
                // Reading column 0 while it is empty is an underflow; the
                // sequence still runs to completion so timing stays fixed.
                if (glb_empty_i[0]) begin
                    err_next = 1'b1;
                end
                if (cnt_last) begin
                    cnt_next   = '0;
                    state_next = SKEW;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            SKEW: begin
                // The last column's final delayed read lands one cycle before
                // the end of this phase, so every column must be empty here.
                if (cnt_last) begin
                    if (!all_empty) begin
                        err_next = 1'b1;
                    end
                    tile_done_o   = 1'b1;
                    tile_cnt_next = tile_inc;
                    cnt_next      = '0;
                    state_next    = (tile_inc == num_reg) ? FIN : FILL;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            FIN: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign err_o = err_reg;

endmodule

// File: tb/tb_glb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_glb_ctrl
//
// Bench for glb_ctrl with PE_SIZE=4. Each test task pushes the GLB enable
// and status pulses it expects (kind + absolute cycle) into a scoreboard
// queue when it drives stimulus; a negedge monitor pops and compares every
// pulse the controller produces. Tasks also do their own inline checks.
// A small occupancy model of GLB column 0 generates glb_empty_i[0].
// -----------------------------------------------------------------------------
module tb_glb_ctrl;

    localparam int P  = 4;
    localparam int TW = 8;

    localparam int K_WR = 1;
    localparam int K_RD = 2;
    localparam int K_TD = 3;
    localparam int K_DN = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [TW-1:0] num_tiles = '0;
    logic          src_valid = 1'b0;
    logic [P-1:0]  full = '0;
    logic [P-1:0]  empty;
    logic [P-1:0]  empty_clr = '0;
    logic          empty0_force = 1'b0;

    logic src_ready, wren, rden, busy, tile_done, done, err;

    int cyc = 0;
    int occ = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t exp_q[$];

    glb_ctrl #(
        .PE_SIZE(P),
        .TILE_W (TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .num_tiles_i(num_tiles),
        .src_valid_i(src_valid),
        .src_ready_o(src_ready),
        .glb_wren_o (wren),
        .glb_rden_o (rden),
        .glb_full_i (full),
        .glb_empty_i(empty),
        .busy_o     (busy),
        .tile_done_o(tile_done),
        .done_o     (done),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Column-0 occupancy of the GLB, driven by the enables it receives.
    always @(posedge clk or posedge rst) begin
        if (rst) occ <= 0;
        else     occ <= occ + (wren ? 1 : 0) - (rden ? 1 : 0);
    end

    always_comb begin
        empty    = ~empty_clr;
        empty[0] = empty0_force | (occ == 0);
    end

    // Scoreboard monitor: every pulse must match the head of the queue.
    always @(negedge clk) begin
        int  n;
        int  k;
        ev_t e;
        if (!rst) begin
            n = int'(wren) + int'(rden) + int'(tile_done) + int'(done);
            if (n > 1) begin
                checks++;
                failures++;
                $display("FAIL sb_overlap cyc=%0d wren=%b rden=%b tile_done=%b done=%b required at most one high",
                         cyc, wren, rden, tile_done, done);
            end else if (n == 1) begin
                k = wren ? K_WR : (rden ? K_RD : (tile_done ? K_TD : K_DN));
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected got kind=%0d cyc=%0d required no pulse", k, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind !== k || e.cyc !== cyc) begin
                        failures++;
                        $display("FAIL sb_event got kind=%0d cyc=%0d required kind=%0d cyc=%0d",
                                 k, cyc, e.kind, e.cyc);
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns s = cycle on which start is high; returns in cycle s+1.
    task automatic pulse_start(input logic [TW-1:0] n, output int s);
        @(posedge clk);
        #1;
        s         = cyc;
        num_tiles = n;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push_ev(input int kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Four read strobes from cycle d, tile_done 2*P-1 cycles after the first.
    task automatic push_drain(input int d);
        for (int i = 0; i < P; i++) push_ev(K_RD, d + i);
        push_ev(K_TD, d + 2 * P - 1);
    endtask

    // Unstalled tile whose first write is on cycle b.
    task automatic push_tile(input int b);
        for (int i = 0; i < P; i++) push_ev(K_WR, b + i);
        push_drain(b + P);
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        step(3);
        checks++;
        if ({busy, src_ready, wren, rden, tile_done, done, err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs got %b required 0000000",
                     {busy, src_ready, wren, rden, tile_done, done, err});
        end
        rst = 1'b0;
        step(2);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy=%b required 0", busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_one_tile();
        int s;
        exp_q.delete();
        src_valid = 1'b1;
        pulse_start(8'd1, s);
        push_tile(s + 1);
        push_ev(K_DN, s + 13);
        step(5);
        // start in DRAIN must be ignored
        num_tiles = 8'd5;
        start     = 1'b1;
        step(1);
        start = 1'b0;
        step(9);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL one_tile_pending got %0d left required 0", exp_q.size());
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL one_tile_err got %b required 0", err);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL one_tile_busy got %b required 0", busy);
        end
        $display("test_one_tile start_cyc=%0d", s);
    endtask

    task automatic test_multi_tile();
        int s;
        exp_q.delete();
        src_valid = 1'b1;
        pulse_start(8'd3, s);
        for (int t = 0; t < 3; t++) push_tile(s + 1 + 12 * t);
        push_ev(K_DN, s + 37);
        step(39);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL multi_pending got %0d left required 0", exp_q.size());
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL multi_err got %b required 0", err);
        end
        $display("test_multi_tile start_cyc=%0d", s);
    endtask

    task automatic test_stalls();
        int   s;
        logic exp_w;
        exp_q.delete();
        src_valid = 1'b0;
        pulse_start(8'd1, s);
        for (int i = 0; i < P; i++) push_ev(K_WR, s + 1 + 3 * i);
        push_drain(s + 11);
        push_ev(K_DN, s + 19);
        for (int k = 0; k < 12; k++) begin
            src_valid = (k % 3 == 0);
            @(negedge clk);
            exp_w = (k % 3 == 0) && (k <= 9);
            checks++;
            if (wren !== exp_w) begin
                failures++;
                $display("FAIL stall_wren k=%0d got %b required %b", k, wren, exp_w);
            end
            step(1);
        end
        src_valid = 1'b1;
        step(8);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL stall_pending got %0d left required 0", exp_q.size());
        end
        $display("test_stalls start_cyc=%0d", s);
    endtask

    task automatic test_full();
        int   s;
        logic exp_r;
        exp_q.delete();
        src_valid = 1'b1;
        pulse_start(8'd1, s);
        push_ev(K_WR, s + 1);
        for (int i = 5; i <= 7; i++) push_ev(K_WR, s + i);
        push_drain(s + 8);
        push_ev(K_DN, s + 16);
        for (int k = 0; k < 9; k++) begin
            full = (k >= 1 && k <= 3) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            exp_r = (k < 7) && !(k >= 1 && k <= 3);
            checks++;
            if (src_ready !== exp_r) begin
                failures++;
                $display("FAIL full_ready k=%0d got %b required %b", k, src_ready, exp_r);
            end
            step(1);
        end
        full = '0;
        step(8);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL full_pending got %0d left required 0", exp_q.size());
        end
        $display("test_full start_cyc=%0d", s);
    endtask

    task automatic test_zero_tiles();
        int s;
        exp_q.delete();
        src_valid = 1'b1;
        pulse_start(8'd0, s);
        push_ev(K_DN, s + 1);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL zero_busy got %b required 1", busy);
        end
        step(3);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_end got pending=%0d busy=%b required 0 0", exp_q.size(), busy);
        end
        $display("test_zero_tiles start_cyc=%0d", s);
    endtask

    task automatic test_empty_check();
        int s;
        int s2;
        exp_q.delete();
        src_valid = 1'b1;
        empty_clr = 4'b1000;
        pulse_start(8'd1, s);
        push_tile(s + 1);
        push_ev(K_DN, s + 13);
        step(12);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL empty_err_set got %b required 1", err);
        end
        step(5);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL empty_err_sticky got %b required 1", err);
        end
        empty_clr = '0;
        pulse_start(8'd0, s2);
        push_ev(K_DN, s2 + 1);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL empty_err_clear got %b required 0", err);
        end
        step(2);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL empty_pending got %0d left required 0", exp_q.size());
        end
        $display("test_empty_check start_cyc=%0d", s);
    endtask

    task automatic test_underflow();
        int s;
        exp_q.delete();
        src_valid    = 1'b1;
        empty0_force = 1'b1;
        pulse_start(8'd1, s);
        push_tile(s + 1);
        push_ev(K_DN, s + 13);
        step(4);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL underflow_pre got %b required 0", err);
        end
        step(1);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL underflow_err got %b required 1", err);
        end
        step(10);
        empty0_force = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL underflow_pending got %0d left required 0", exp_q.size());
        end
        $display("test_underflow start_cyc=%0d", s);
    endtask

    task automatic test_reset_mid();
        int s;
        int s2;
        exp_q.delete();
        src_valid = 1'b1;
        pulse_start(8'd1, s);
        for (int i = 0; i < P; i++) push_ev(K_WR, s + 1 + i);
        for (int i = 0; i < P; i++) push_ev(K_RD, s + 5 + i);
        step(9);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_busy got %b required 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, src_ready, wren, rden, tile_done, done, err} !== 7'b0) begin
            failures++;
            $display("FAIL rstmid_outputs got %b required 0000000",
                     {busy, src_ready, wren, rden, tile_done, done, err});
        end
        step(2);
        rst = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rstmid_pending got %0d left required 0", exp_q.size());
        end
        pulse_start(8'd0, s2);
        push_ev(K_DN, s2 + 1);
        step(3);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_recover got pending=%0d busy=%b required 0 0", exp_q.size(), busy);
        end
        $display("test_reset_mid start_cyc=%0d", s);
    endtask

    initial begin
        test_reset();
        test_one_tile();
        test_multi_tile();
        test_stalls();
        test_full();
        test_zero_tiles();
        test_empty_check();
        test_underflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
